c_mat_drain: RTL

- Readout engine directly downstream of the C-matrix result SRAM (M x N, row-major, one-port read with c_rvalid response).
- On start, it issues one read per element of the M x N tile and streams the returned words out over a valid/ready interface, tagged with row/col and last.
- Credit-based issue plus a local FIFO mean downstream backpressure never loses SRAM read data.

---
 rtl/c_mat_drain.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/c_mat_drain.sv
// c_mat_drain: reads an M x N C tile out of the result SRAM and streams it
// over valid/ready, tagged with row, col and last.
// Reads are only issued when the local FIFO is guaranteed to have room for
// them (credit = inflight + fifo_count < FIFO_DEPTH). Downstream backpressure
// therefore can never drop returning SRAM data.
// Optional build macro: C_DRAIN_COLMAJOR_EN switches both the issue and the
// output traversal from row-major to column-major.
//
// state | meaning
// IDLE  | waiting for start; issue/output indices rest at (0,0)
// ISSUE | issuing one read per cycle while credit allows
// DRAIN | all reads issued; waiting for the last beat to handshake
module c_mat_drain #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W      = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              c_en,
  output logic              c_re,
  output logic [ROW_W-1:0]  c_row,
  output logic [COL_W-1:0]  c_col,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rvalid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ROW_W-1:0]  m_row,
  output logic [COL_W-1:0]  m_col,
  output logic              m_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   iss_row;
  logic [COL_W-1:0]   iss_col;
  logic [ROW_W-1:0]   out_row;
  logic [COL_W-1:0]   out_col;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [CNT_W:0]     occ;
  logic               credit, issue, push, pop;
  logic               start_acc, iss_last, out_last, hs_last;

  // Fully wrapping step, so both indices return to (0,0) after the last element.
  function automatic logic [ROW_W+COL_W-1:0] step_idx(input logic [ROW_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
    logic [ROW_W-1:0] nr;
    logic [COL_W-1:0] nc;
    nr = r;
    nc = c;
`ifdef C_DRAIN_COLMAJOR_EN
    if (r == ROW_LAST) begin
      nr = '0;
      nc = (c == COL_LAST) ? '0 : c + COL_W'(1);
    end else begin
      nr = r + ROW_W'(1);
    end
`else
    if (c == COL_LAST) begin
      nc = '0;
      nr = (r == ROW_LAST) ? '0 : r + ROW_W'(1);
    end else begin
      nc = c + COL_W'(1);
    end
`endif
    return {nr, nc};
  endfunction

  assign occ       = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit    = occ < DEPTH_C;
  assign start_acc = (state == IDLE) && start;
  assign iss_last  = (iss_row == ROW_LAST) && (iss_col == COL_LAST);
  assign out_last  = (out_row == ROW_LAST) && (out_col == COL_LAST);
  assign push      = c_rvalid && (inflight != '0);
  assign pop       = m_valid && m_ready;
  assign hs_last   = pop && out_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = iss_last ? DRAIN : ISSUE;
      ISSUE:   if (issue && iss_last) state_nxt = DRAIN;
      DRAIN:   if (hs_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; the first read is issued straight from IDLE on start
  always_comb begin
    busy    = (state != IDLE);
    issue   = start_acc || ((state == ISSUE) && credit);
    c_re    = c_en;
    m_valid = (fifo_cnt != '0);
    m_last  = m_valid && out_last;
    m_data  = mem[rd_ptr];
    m_row   = out_row;
    m_col   = out_col;
  end

  // Registered SRAM read port and issue index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_en    <= 1'b0;
      c_row   <= '0;
      c_col   <= '0;
      iss_row <= '0;
      iss_col <= '0;
    end else begin
      c_en <= issue;
      if (issue) begin
        c_row              <= iss_row;
        c_col              <= iss_col;
        {iss_row, iss_col} <= step_idx(iss_row, iss_col);
      end
    end
  end

  // Reads in flight; a response with nothing outstanding is stale and ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                inflight <= '0;
    else if (start_acc)        inflight <= CNT_W'(1);
    else if (issue && !push)   inflight <= inflight + CNT_W'(1);
    else if (!issue && push)   inflight <= inflight - CNT_W'(1);
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (start_acc) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= c_rdata;
  end

  // Output index; data returns in order so the tag is recomputed, not stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (start_acc) begin
      out_row <= '0;
      out_col <= '0;
    end else if (pop) begin
      {out_row, out_col} <= step_idx(out_row, out_col);
    end
  end

  // One-cycle completion pulse after the final beat handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == DRAIN) && hs_last;
  end

endmodule
